txn_profiler: RTL and testbench
===============================

TXN_PROFILER -- requirements
Module: txn_profiler

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of cycle, latency and interval counters.
REQ-002 SHALL have parameter TXN_ID_W, default 16, width of the transaction sequence number.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, record buffer depth; power of two, >= 2.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports ap_start, ap_done, ap_continue  in  1 each  ap_ctrl_hs handshake of the observed module.
REQ-007 SHALL have port finish  in  1  end-of-simulation indication.
REQ-008 SHALL have ports rec_valid out 1 and rec_ready in 1  record output handshake.
REQ-009 SHALL have ports rec_txn_id out TXN_ID_W, rec_start_cycle, rec_latency and rec_interval out CNT_W each, rec_incomplete out 1  head-of-FIFO record fields.
REQ-010 SHALL have ports busy out 1 (state RUN), overflow out 1 (sticky) and drop_count out 16.

Function
REQ-011 SHALL run a free cycle counter that is 0 on the first cycle after reset release, +1 per cycle, wrapping modulo 2^CNT_W.
REQ-012 SHALL implement states IDLE, RUN and STOPPED; reset state IDLE.
REQ-013 IDLE->RUN when ap_start=1 and finish=0; start_cycle latched from the cycle counter in that cycle.
REQ-014 RUN->IDLE when ap_done=1 and ap_continue=1; latency = current cycle - start_cycle, modulo 2^CNT_W.
REQ-015 ap_start and ap_done both high in IDLE SHALL produce one record with latency 0; state stays IDLE.
REQ-016 ap_start in the cycle that closes a transaction SHALL NOT open a new one; ap_start is re-sampled next cycle.
REQ-017 interval = start_cycle of this transaction - start_cycle of the previous one, modulo 2^CNT_W; 0 for the first transaction after reset.
REQ-018 txn_id SHALL start at 0 and increment by 1 per closed or incomplete record, wrapping at 2^TXN_ID_W, including dropped records.
REQ-019 A record SHALL be written into the FIFO in the cycle after its closing event; rec_valid SHALL rise no earlier than the following cycle.
REQ-020 FIFO SHALL be first-word-fall-through; pop when rec_valid=1 and rec_ready=1; rec_valid SHALL hold and outputs SHALL stay stable until popped.
REQ-021 Push and pop in the same cycle while full SHALL both succeed, with no drop.
REQ-022 Push while full without a pop SHALL discard the new record, set overflow and saturate-increment drop_count at 16'hFFFF.
REQ-023 finish=1 in RUN SHALL push one record with rec_incomplete=1 and latency = current cycle - start_cycle, then enter STOPPED.
REQ-024 finish=1 in IDLE SHALL enter STOPPED with no record.
REQ-025 STOPPED SHALL be terminal until reset: no new records; the FIFO keeps draining.
REQ-026 ap_done while in RUN with ap_continue=0 SHALL be ignored.

Reset
REQ-027 Reset assertion SHALL asynchronously clear the state to IDLE and clear cycle counter, txn_id, FIFO pointers, overflow and drop_count.
REQ-028 During reset, rec_valid=0, busy=0, overflow=0, drop_count=0, and all rec_* data fields SHALL read 0.
REQ-029 Reset mid-transaction SHALL discard the in-flight transaction and all buffered records with no partial record.

Configuration
REQ-030 Macro TXN_PROFILER_INTERVAL_EN defined SHALL compile in the previous-start register and interval computation per REQ-017.
REQ-031 Without TXN_PROFILER_INTERVAL_EN, rec_interval SHALL be constant 0 and no interval storage SHALL be built; all other behaviour unchanged.

Verification
REQ-032 Start at cycle 5, done+continue at cycle 12 -> one record: id 0, start 5, latency 7, interval 0, incomplete 0.
REQ-033 Second start at cycle 20, done at 23 -> id 1, latency 3, interval 15 (0 when the macro is undefined).
REQ-034 rec_ready=0, 9 single-cycle transactions with FIFO_DEPTH=8 -> 8 records held, overflow=1, drop_count=1, next id 9.
REQ-035 Start at cycle 30, finish at cycle 34 -> record latency 4, incomplete 1, then state STOPPED, and later ap_start yields no records.
REQ-036 Reset pulse at cycle 40 of a transaction started at cycle 36 -> rec_valid=0, busy=0, and the next record after release has id 0.
REQ-037 Start and done both high in IDLE at cycle 3 -> latency 0, state IDLE, and ap_start held high opens the next transaction at cycle 4.

Source files
------------

// File: rtl/txn_profiler.sv
// Transaction profiler for an ap_ctrl_hs block: start cycle, latency and sequence number per call, queued in a FWFT FIFO.
// Optional macro TXN_PROFILER_INTERVAL_EN adds start-to-start interval tracking.
module txn_profiler #(
  parameter int CNT_W      = 32,
  parameter int TXN_ID_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ap_start,
  input  logic                ap_done,
  input  logic                ap_continue,
  input  logic                finish,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [TXN_ID_W-1:0] rec_txn_id,
  output logic [CNT_W-1:0]    rec_start_cycle,
  output logic [CNT_W-1:0]    rec_latency,
  output logic [CNT_W-1:0]    rec_interval,
  output logic                rec_incomplete,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         drop_count,
  output logic [1:0]          state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STOPPED = 2'd2
  } state_t;

  typedef struct packed {
    logic [TXN_ID_W-1:0] txn_id;
    logic [CNT_W-1:0]    start_cycle;
    logic [CNT_W-1:0]    latency;
`ifdef TXN_PROFILER_INTERVAL_EN
    logic [CNT_W-1:0]    interval;
`endif
    logic                incomplete;
  } rec_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cycle;
  logic [CNT_W-1:0]    r_start;
  logic [TXN_ID_W-1:0] r_txn_id;
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic                r_overflow;
  logic [15:0]         r_drop_count;
  rec_t                r_mem [FIFO_DEPTH];

  logic w_open;
  logic w_push;
  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;
  rec_t w_rec;
  rec_t w_head;

  // Handshake: a record leaves the FIFO on a rising edge where rec_valid and rec_ready are both high;
  // while rec_valid is high and rec_ready low, the head record and rec_valid hold steady.
  assign w_open = (r_state == S_IDLE) && !finish && ap_start;

`ifdef TXN_PROFILER_INTERVAL_EN
  logic [CNT_W-1:0] r_prev_start;
  logic [CNT_W-1:0] r_interval;
  logic             r_has_prev;
  logic [CNT_W-1:0] w_open_interval;
  logic [CNT_W-1:0] w_interval;

  assign w_open_interval = r_has_prev ? (r_cycle - r_prev_start) : '0;
  assign w_interval      = (r_state == S_IDLE) ? w_open_interval : r_interval;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_start <= '0;
      r_interval   <= '0;
      r_has_prev   <= 1'b0;
    end else if (w_open) begin
      r_prev_start <= r_cycle;
      r_interval   <= w_open_interval;
      r_has_prev   <= 1'b1;
    end
  end

  assign rec_interval = rec_valid ? w_head.interval : '0;
`else
  assign rec_interval = '0;
`endif

  always_comb begin
    w_push        = 1'b0;
    w_rec         = '0;
    w_rec.txn_id  = r_txn_id;
    case (r_state)
      S_IDLE: begin
        if (w_open && ap_done) begin
          w_push            = 1'b1;
          w_rec.start_cycle = r_cycle;
        end
      end
      S_RUN: begin
        if (finish || (ap_done && ap_continue)) begin
          w_push            = 1'b1;
          w_rec.start_cycle = r_start;
          w_rec.latency     = r_cycle - r_start;
          w_rec.incomplete  = finish && !(ap_done && ap_continue);
        end
      end
      default: ;
    endcase
`ifdef TXN_PROFILER_INTERVAL_EN
    w_rec.interval = w_interval;
`endif
  end

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign rec_valid = (r_wr_ptr != r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = rec_valid && rec_ready;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cycle      <= '0;
      r_start      <= '0;
      r_txn_id     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_push) r_txn_id <= r_txn_id + TXN_ID_W'(1);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (finish) begin
            r_state <= S_STOPPED;
          end else if (ap_start && !ap_done) begin
            r_state <= S_RUN;
            r_start <= r_cycle;
          end
        end
        S_RUN: begin
          if (finish) r_state <= S_STOPPED;
          else if (ap_done && ap_continue) r_state <= S_IDLE;
        end
        S_STOPPED: r_state <= S_STOPPED;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rec_txn_id      = rec_valid ? w_head.txn_id : '0;
  assign rec_start_cycle = rec_valid ? w_head.start_cycle : '0;
  assign rec_latency     = rec_valid ? w_head.latency : '0;
  assign rec_incomplete  = rec_valid && w_head.incomplete;
  assign busy            = (r_state == S_RUN);
  assign overflow        = r_overflow;
  assign drop_count      = r_drop_count;
  assign state_dbg       = r_state;

endmodule

// File: tb/tb_txn_profiler.sv
// Bench for txn_profiler: directed scenarios plus randomized traffic against a transaction-level model,
// with a scoreboard queue of expected records drained by a monitor on rec_valid && rec_ready.
module tb_txn_profiler;

  localparam int CNT_W    = 32;
  localparam int TXN_ID_W = 16;
  localparam int DEPTH    = 8;
  localparam int REC_W    = TXN_ID_W + 3 * CNT_W + 1;
`ifdef TXN_PROFILER_INTERVAL_EN
  localparam logic [CNT_W-1:0] IV_SECOND = 32'd15;
`else
  localparam logic [CNT_W-1:0] IV_SECOND = 32'd0;
`endif

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                ap_start = 1'b0;
  logic                ap_done = 1'b0;
  logic                ap_continue = 1'b0;
  logic                finish = 1'b0;
  logic                rec_ready = 1'b0;
  logic                rec_valid;
  logic [TXN_ID_W-1:0] rec_txn_id;
  logic [CNT_W-1:0]    rec_start_cycle;
  logic [CNT_W-1:0]    rec_latency;
  logic [CNT_W-1:0]    rec_interval;
  logic                rec_incomplete;
  logic                busy;
  logic                overflow;
  logic [15:0]         drop_count;
  logic [1:0]          state_dbg;

  always #5 clock = ~clock;

  txn_profiler #(.CNT_W(CNT_W), .TXN_ID_W(TXN_ID_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_txn_id(rec_txn_id), .rec_start_cycle(rec_start_cycle), .rec_latency(rec_latency),
    .rec_interval(rec_interval), .rec_incomplete(rec_incomplete), .busy(busy),
    .overflow(overflow), .drop_count(drop_count), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [REC_W-1:0] exp_q[$];

  // Reference model: transaction bookkeeping and a bounded record list.
  logic [CNT_W-1:0]    cyc;
  logic [CNT_W-1:0]    m_start;
  logic [CNT_W-1:0]    m_prev;
  logic [CNT_W-1:0]    m_iv;
  logic                m_have_prev;
  logic                m_in_txn;
  logic                m_stopped;
  logic                m_ovf;
  logic [TXN_ID_W-1:0] m_id;
  logic [15:0]         m_drops;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [REC_W-1:0] pack(input logic [TXN_ID_W-1:0] id, input logic [CNT_W-1:0] st,
                                            input logic [CNT_W-1:0] lat, input logic [CNT_W-1:0] iv,
                                            input logic inc);
    return {id, st, lat, iv, inc};
  endfunction

  task automatic emit(input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] lat,
                      input logic [CNT_W-1:0] iv, input logic inc);
    logic [CNT_W-1:0] eiv;
`ifdef TXN_PROFILER_INTERVAL_EN
    eiv = iv;
`else
    eiv = '0;
`endif
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(pack(m_id, st, lat, eiv, inc));
    end else begin
      m_ovf = 1'b1;
      if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    end
    m_id = m_id + 1'b1;
  endtask

  task automatic model_step(input logic s, input logic d, input logic c, input logic f);
    logic [CNT_W-1:0] iv;
    if (m_stopped) return;
    if (!m_in_txn) begin
      if (f) begin
        m_stopped = 1'b1;
      end else if (s) begin
        iv = m_have_prev ? cyc - m_prev : '0;
        m_prev = cyc;
        m_have_prev = 1'b1;
        if (d) begin
          emit(cyc, '0, iv, 1'b0);
        end else begin
          m_in_txn = 1'b1;
          m_start = cyc;
          m_iv = iv;
        end
      end
    end else if (f || (d && c)) begin
      emit(m_start, cyc - m_start, m_iv, f && !(d && c));
      m_in_txn = 1'b0;
      m_stopped = f;
    end
  endtask

  task automatic step(input logic s, input logic d, input logic c, input logic f, input logic r);
    ap_start = s;
    ap_done = d;
    ap_continue = c;
    finish = f;
    rec_ready = r;
    @(negedge clock);
    #1;
    model_step(s, d, c, f);
    @(posedge clock);
    #1;
    cyc = cyc + 1'b1;
  endtask

  task automatic idle_to(input int target, input logic r);
    while (cyc < CNT_W'(target)) step(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ap_start = 1'b0;
    ap_done = 1'b0;
    ap_continue = 1'b0;
    finish = 1'b0;
    rec_ready = 1'b0;
    #1;
    chk("reset_rec_valid", rec_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_drop_count", drop_count, 16'd0);
    chk("reset_state", state_dbg, 2'd0);
    chk("reset_rec_fields", {rec_txn_id, rec_start_cycle, rec_latency, rec_interval, rec_incomplete}, '0);
    exp_q.delete();
    m_start = '0;
    m_prev = '0;
    m_iv = '0;
    m_have_prev = 1'b0;
    m_in_txn = 1'b0;
    m_stopped = 1'b0;
    m_ovf = 1'b0;
    m_id = '0;
    m_drops = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = '0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("rec_valid", rec_valid, exp_q.size() != 0);
      chk("busy", busy, m_in_txn);
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drops);
      if (rec_valid && rec_ready && exp_q.size() != 0) begin
        chk("record", {rec_txn_id, rec_start_cycle, rec_latency, rec_interval, rec_incomplete},
            exp_q.pop_front());
      end
    end
  end

  logic rs, rdn, rc, rf, rr;

  initial begin
    #2;
    do_reset();

    // First and second transaction with fixed timing.
    idle_to(5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(12, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_id", rec_txn_id, 16'd0);
    chk("t1_start", rec_start_cycle, 32'd5);
    chk("t1_latency", rec_latency, 32'd7);
    chk("t1_interval", rec_interval, 32'd0);
    chk("t1_incomplete", rec_incomplete, 1'b0);
    idle_to(20, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(23, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_id", rec_txn_id, 16'd1);
    chk("t2_start", rec_start_cycle, 32'd20);
    chk("t2_latency", rec_latency, 32'd3);
    chk("t2_interval", rec_interval, IV_SECOND);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Nine back-to-back records with the consumer stalled.
    do_reset();
    repeat (9) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drops", drop_count, 16'd1);
    chk("ovf_head_id", rec_txn_id, 16'd0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    chk("ovf_drained", rec_valid, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_next_id", rec_txn_id, 16'd9);
    chk("ovf_sticky", overflow, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start and done together in idle, then a held start opens the next call.
    do_reset();
    idle_to(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("zl_state_idle", state_dbg, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("zl_busy", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Finish during a call, then everything afterwards is ignored.
    do_reset();
    idle_to(30, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(34, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fin_start", rec_start_cycle, 32'd30);
    chk("fin_latency", rec_latency, 32'd4);
    chk("fin_incomplete", rec_incomplete, 1'b1);
    chk("fin_state", state_dbg, 2'd2);
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fin_no_records", rec_valid, 1'b0);
    chk("fin_state_hold", state_dbg, 2'd2);

    // Reset while a call is open and a record is buffered.
    do_reset();
    idle_to(2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_to(36, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to(40, 1'b0);
    chk("pre_reset_busy", busy, 1'b1);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_id", rec_txn_id, 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with varying consumer back-pressure.
    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < 600; i++) begin
        rs  = ($urandom_range(0, 2) == 0);
        rdn = ($urandom_range(0, 3) == 0);
        rc  = ($urandom_range(0, 3) != 0);
        rf  = ($urandom_range(0, 399) == 0);
        if (b == 0) rr = 1'b1;
        else if (b == 1) rr = ($urandom_range(0, 1) == 1);
        else rr = ($urandom_range(0, 5) == 0);
        step(rs, rdn, rc, rf, rr);
      end
      repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rand_drained", 128'(exp_q.size()), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
